// File: rtl/axi4lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_reg_slave
// Brief    : AXI4-Lite responder with four 32-bit read/write control
//            registers, exported flat together with a per-register
//            one-cycle write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
  output logic [3:0]                        REG_WR_STB
);

  localparam int c_num_regs = 4;
  localparam int c_strb_w   = C_S_AXI_DATA_WIDTH / 8;

  // Register file and write-path holding state
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [c_num_regs];
  logic                          r_aw_held;
  logic                          r_w_held;
  logic [1:0]                    r_awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]           r_wstrb;
  logic                          r_awready;
  logic                          r_wready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [3:0]                    r_wr_stb;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic [1:0]                    w_addr_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_sel;
  logic [c_strb_w-1:0]           w_strb_sel;
  logic                          w_aw_held_nxt;
  logic                          w_w_held_nxt;
  logic                          w_bvalid_nxt;
  logic                          w_rvalid_nxt;

  // PROT and the byte-offset address bits carry no meaning here
  wire w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;

  // Commit decision, write operand selection and next-state of all handshake flags
  always_comb begin
    w_commit      = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    // A handshake in the commit cycle is fresher than anything latched earlier
    w_addr_sel    = w_aw_hs ? S_AXI_AWADDR[3:2] : r_awaddr;
    w_data_sel    = w_w_hs  ? S_AXI_WDATA       : r_wdata;
    w_strb_sel    = w_w_hs  ? S_AXI_WSTRB       : r_wstrb;
    w_aw_held_nxt = w_commit ? 1'b0 : (r_aw_held || w_aw_hs);
    w_w_held_nxt  = w_commit ? 1'b0 : (r_w_held  || w_w_hs);
    w_bvalid_nxt  = w_commit ? 1'b1 : (r_bvalid && !S_AXI_BREADY);
    w_rvalid_nxt  = w_ar_hs  ? 1'b1 : (r_rvalid && !S_AXI_RREADY);
  end

  // Write channel: hold AW/W independently, commit bytewise, raise B
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_wr_stb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= S_AXI_AWADDR[3:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        for (int b = 0; b < c_strb_w; b++) begin
          if (w_strb_sel[b]) begin
            r_regs[w_addr_sel][8*b +: 8] <= w_data_sel[8*b +: 8];
          end
        end
      end
      r_wr_stb  <= w_commit ? (4'b0001 << w_addr_sel) : 4'b0000;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      // Readies stay low until the outstanding B has been taken
      r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
      r_wready  <= !w_w_held_nxt  && !w_bvalid_nxt;
    end
  end

  // Read channel: capture the addressed register (pre-write value on a collision)
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
      end
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= !w_rvalid_nxt;
    end
  end

  generate
    for (genvar n = 0; n < c_num_regs; n++) begin : g_reg_out
      assign REG_OUT[C_S_AXI_DATA_WIDTH*n +: C_S_AXI_DATA_WIDTH] = r_regs[n];
    end
  endgenerate

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign REG_WR_STB    = r_wr_stb;

endmodule
`default_nettype wire
